// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2,
    RETURN  = 2'd3
  } irq_state_e;

  localparam int MCAUSE_INTERRUPT_BIT = 31;
  localparam int CAUSE_BASE_DEFAULT   = 16;

  // mcause value for an interrupt: exception code base+idx with the interrupt bit set
  function automatic logic [31:0] mcause(input int base, input int idx);
    logic [31:0] c;
    c = 32'(base + idx);
    c[MCAUSE_INTERRUPT_BIT] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: valid flag, binary index and one-hot grant.
module irq_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  // scan high to low so the lowest set bit is the last assignment; isolate it for the one-hot
  always_comb begin
    valid  = |req;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) idx = IDX_W'(k);
    end
    onehot = req & (~req + N'(1));
  end

endmodule

// File: rtl/irq_controller.sv
// Machine-mode interrupt controller: sticky pending, mie masking, fixed priority,
// trap pulse + mcause for the CSR unit, one-hot acknowledge on mret.
// Build option: define IRQ_EDGE_EN for rising-edge request capture (default: level).
module irq_controller
  import irq_pkg::*;
#(
  parameter int IRQ_NUM    = 16,
  parameter int CAUSE_BASE = CAUSE_BASE_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [IRQ_NUM-1:0] irq_req_i,
  input  logic [31:0]        mie_i,
  input  logic               exception_i,
  input  logic               stall_i,
  input  logic               mret_i,
  output logic               irq_o,
  output logic [31:0]        irq_cause_o,
  output logic [IRQ_NUM-1:0] irq_ret_o,
  output logic               busy_o
);

  localparam int IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

  irq_state_e         state, state_nxt;
  logic [IRQ_NUM-1:0] pending, pend_set, pend_clr, eligible;
  logic [IRQ_NUM-1:0] win_oh, idx_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic               take;
  logic [31:0]        cause_q;
  logic               unused_mie;

`ifdef IRQ_EDGE_EN
  logic [IRQ_NUM-1:0] req_prev;

  // previous request level, so a held line pends only once per rising edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) req_prev <= '0;
    else         req_prev <= irq_req_i;
  end

  assign pend_set = irq_req_i & ~req_prev;
`else
  assign pend_set = irq_req_i;
`endif

  // only the serviced line is cleared, and only in the acknowledge cycle
  assign pend_clr = (state == RETURN) ? idx_oh : '0;

  // sticky pending bits; clear dominates a coincident set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending <= '0;
    else         pending <= (pending | pend_set) & ~pend_clr;
  end

  assign eligible   = pending & mie_i[CAUSE_BASE +: IRQ_NUM];
  // mie bits outside this controller's window are intentionally ignored
  assign unused_mie = ^mie_i;

  irq_prio_enc #(.N(IRQ_NUM), .IDX_W(IDX_W)) u_prio (
    .req    (eligible),
    .valid  (win_vld),
    .idx    (win_idx),
    .onehot (win_oh)
  );

  assign take = (state == IDLE) && win_vld && !exception_i && !stall_i;

  // capture the winner at entry; later mie/pending changes cannot alter the in-service line
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_oh  <= '0;
      cause_q <= '0;
    end else if (take) begin
      idx_oh  <= win_oh;
      cause_q <= mcause(CAUSE_BASE, int'(win_idx));
    end
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // next state and trap pulse; no nesting, mret outside SERVICE is ignored
  always_comb begin
    state_nxt = state;
    irq_o     = 1'b0;
    unique case (state)
      IDLE:    if (take) state_nxt = TAKE;
      TAKE: begin
        irq_o = !stall_i;
        if (!stall_i) state_nxt = SERVICE;
      end
      SERVICE: if (mret_i) state_nxt = RETURN;
      RETURN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign irq_ret_o   = (state == RETURN) ? idx_oh : '0;
  assign busy_o      = (state != IDLE);
  assign irq_cause_o = cause_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: expected causes/acks are queued when stimulus
// is driven and popped by a negedge monitor whenever the DUT pulses irq_o or irq_ret_o.
module tb_irq_controller;

  logic        clk;
  logic        rst_ni;
  logic [15:0] irq_req_i;
  logic [31:0] mie_i;
  logic        exception_i;
  logic        stall_i;
  logic        mret_i;
  logic        irq_o;
  logic [31:0] irq_cause_o;
  logic [15:0] irq_ret_o;
  logic        busy_o;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] exp_cause[$];
  logic [15:0] exp_ret[$];

  irq_controller #(.IRQ_NUM(16), .CAUSE_BASE(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .irq_req_i   (irq_req_i),
    .mie_i       (mie_i),
    .exception_i (exception_i),
    .stall_i     (stall_i),
    .mret_i      (mret_i),
    .irq_o       (irq_o),
    .irq_cause_o (irq_cause_o),
    .irq_ret_o   (irq_ret_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every trap pulse and acknowledge must match the next queued expectation
  always @(negedge clk) begin
    if (irq_o === 1'b1) begin
      vectors++;
      assert (exp_cause.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_irq: observed cause %h expected no trap", irq_cause_o);
      end
      if (exp_cause.size() != 0) chk("sb_cause", irq_cause_o, exp_cause.pop_front());
    end
    if (irq_ret_o !== 16'h0000) begin
      vectors++;
      assert (exp_ret.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_ret: observed %h expected 0000", irq_ret_o);
      end
      if (exp_ret.size() != 0) chk("sb_ret", {16'h0, irq_ret_o}, {16'h0, exp_ret.pop_front()});
    end
  end

  initial begin
    irq_req_i = '0; mie_i = '0; exception_i = 0; stall_i = 0; mret_i = 0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_busy",  busy_o,      0);
    chk("rst_irq",   irq_o,       0);
    chk("rst_cause", irq_cause_o, 0);
    chk("rst_ret",   irq_ret_o,   0);
    step(); step();
    rst_ni = 1'b1;
    step();

    // basic entry on line 0
    mie_i = 32'h0001_0000; irq_req_i = 16'h0001;
    exp_cause.push_back(32'h8000_0010); exp_ret.push_back(16'h0001);
    step(); irq_req_i = '0;
    chk("basic_idle_busy", busy_o, 0);
    step();
    chk("basic_irq", irq_o, 1);
    chk("basic_cause", irq_cause_o, 32'h8000_0010);
    chk("basic_busy", busy_o, 1);
    step();
    chk("basic_irq_single", irq_o, 0);
    mret_i = 1; step(); mret_i = 0;
    chk("basic_ret", irq_ret_o, 16'h0001);
    step();
    chk("basic_ret_single", irq_ret_o, 0);
    chk("basic_busy_end", busy_o, 0);

    // mret in IDLE is ignored
    mret_i = 1; step(); mret_i = 0;
    chk("idle_mret_ret", irq_ret_o, 0);
    chk("idle_mret_busy", busy_o, 0);

    // priority: lines 2 and 4 together, line 2 first
    mie_i = 32'hFFFF_0000; irq_req_i = 16'h0014;
    exp_cause.push_back(32'h8000_0012); exp_ret.push_back(16'h0004);
    exp_cause.push_back(32'h8000_0014); exp_ret.push_back(16'h0010);
    step(); irq_req_i = '0;
    step();
    chk("prio_first_cause", irq_cause_o, 32'h8000_0012);
    step();
    mret_i = 1; step(); mret_i = 0;
    chk("prio_first_ret", irq_ret_o, 16'h0004);
    step();
    chk("prio_gap_busy", busy_o, 0);
    step();
    chk("prio_second_irq", irq_o, 1);
    chk("prio_second_cause", irq_cause_o, 32'h8000_0014);
    step();
    mret_i = 1; step(); mret_i = 0;
    chk("prio_second_ret", irq_ret_o, 16'h0010);
    step();

    // masked line 3 stays pending, taken once unmasked
    mie_i = '0; irq_req_i = 16'h0008;
    step(); irq_req_i = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("mask_no_irq", irq_o, 0);
      chk("mask_no_busy", busy_o, 0);
    end
    mie_i = 32'h0008_0000;
    exp_cause.push_back(32'h8000_0013); exp_ret.push_back(16'h0008);
    step();
    chk("unmask_irq", irq_o, 1);
    chk("unmask_cause", irq_cause_o, 32'h8000_0013);
    step();
    mret_i = 1; step(); mret_i = 0;
    step();

    // exception blocks entry; stall in TAKE suppresses the pulse
    mie_i = 32'h0001_0000; exception_i = 1; irq_req_i = 16'h0001;
    step(); irq_req_i = '0;
    step();
    chk("exc_block_1", busy_o, 0);
    step();
    chk("exc_block_2", busy_o, 0);
    exception_i = 0;
    exp_cause.push_back(32'h8000_0010); exp_ret.push_back(16'h0001);
    step();
    stall_i = 1; #1;
    chk("stall_take_irq", irq_o, 0);
    chk("stall_take_busy", busy_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_irq", irq_o, 0);
      chk("stall_hold_cause", irq_cause_o, 32'h8000_0010);
    end
    stall_i = 0; #1;
    chk("stall_release_irq", irq_o, 1);
    step();
    chk("stall_after_irq", irq_o, 0);
    mret_i = 1; step(); mret_i = 0;
    chk("stall_ret", irq_ret_o, 16'h0001);
    step();

    // async reset in SERVICE drops everything, including a newer pending line
    mie_i = 32'hFFFF_0000; irq_req_i = 16'h0001;
    exp_cause.push_back(32'h8000_0010);
    step(); irq_req_i = '0;
    step(); step();
    irq_req_i = 16'h0004;
    step(); irq_req_i = '0;
    chk("svc_busy", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_ret", irq_ret_o, 0);
    chk("arst_cause", irq_cause_o, 0);
    step(); step();
    rst_ni = 1'b1;
    mret_i = 1; step(); mret_i = 0;
    chk("arst_mret_ret", irq_ret_o, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("arst_no_busy", busy_o, 0);
    end

    // line 1 held across mret
    irq_req_i = 16'h0002;
    exp_cause.push_back(32'h8000_0011); exp_ret.push_back(16'h0002);
`ifndef IRQ_EDGE_EN
    exp_cause.push_back(32'h8000_0011); exp_ret.push_back(16'h0002);
`endif
    step(); step();
    chk("held_cause", irq_cause_o, 32'h8000_0011);
    step();
    mret_i = 1; step(); mret_i = 0;
    step();
    step(); step();
`ifdef IRQ_EDGE_EN
    chk("held_no_retake", busy_o, 0);
`else
    chk("held_retake_busy", busy_o, 1);
    chk("held_retake_cause", irq_cause_o, 32'h8000_0011);
`endif
    irq_req_i = '0;
    step();
    mret_i = 1; step(); mret_i = 0;
    step(); step();
    chk("end_busy", busy_o, 0);
    chk("sb_cause_drained", exp_cause.size(), 0);
    chk("sb_ret_drained", exp_ret.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
